f1_start_sequencer: RTL

//  Top-level race-start controller for the Formula One lights game. Sequences the
//  ten-light ramp, the random hold before lights-out, and the reaction-time counter.

---
 rtl/f1_start_sequencer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/f1_start_sequencer.sv
// Race-start controller: ten-light ramp, random hold, reaction timer, jump-start detection.
// Optional macro F1_BEST_TIME_EN enables the best-time register (otherwise best_ms_o is tied to MAX_MS).
module f1_start_sequencer #(
  parameter int LEDS         = 10,
  parameter int STEP_MS      = 500,
  parameter int MIN_DELAY_MS = 200,
  parameter int RAND_W       = 10,
  parameter int CNT_W        = 14,
  parameter int MAX_MS       = 9999
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_i,
  input  logic              trigger_i,
  input  logic              press_i,
  input  logic [RAND_W-1:0] rand_val_i,
  output logic              en_lfsr_o,
  output logic [LEDS-1:0]   ledr_o,
  output logic              lights_out_o,
  output logic              result_valid_o,
  output logic [CNT_W-1:0]  react_ms_o,
  output logic [CNT_W-1:0]  best_ms_o,
  output logic              jump_start_o
);

  localparam int LIT_W = $clog2(LEDS + 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_MS - 1);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_MS);
  localparam logic [CNT_W-1:0] MIN_DLY   = CNT_W'(MIN_DELAY_MS);
  localparam logic [LIT_W-1:0] LIT_FULL  = LIT_W'(LEDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RAMP   = 3'd1,
    S_HOLD   = 3'd2,
    S_TIMING = 3'd3,
    S_DONE   = 3'd4,
    S_JUMP   = 3'd5
  } state_t;

  state_t           state_q;
  logic             trig_q;
  logic             press_q;
  logic [CNT_W-1:0] ms_cnt_q;
  logic [CNT_W-1:0] rt_cnt_q;
  logic [CNT_W-1:0] delay_q;
  logic [LIT_W-1:0] lit_q;
  logic [LEDS-1:0]  ledr_q;
  logic             en_lfsr_q;
  logic             lights_out_q;
  logic             result_valid_q;
  logic [CNT_W-1:0] react_ms_q;
  logic             jump_start_q;

  logic             trig_e;
  logic             press_e;
  logic [CNT_W-1:0] ms_cnt_d;
  logic [CNT_W-1:0] rt_cnt_d;
  logic [CNT_W-1:0] delay_d;
  logic [LIT_W-1:0] lit_d;
  logic             start_run;
  logic             jump_now;

  function automatic logic [LEDS-1:0] bar(input logic [LIT_W-1:0] n);
    logic [LEDS-1:0] m;
    m = '0;
    for (int i = 0; i < LEDS; i++) begin
      m[i] = (i < int'(n));
    end
    return m;
  endfunction

  assign trig_e   = trigger_i & ~trig_q;
  assign press_e  = press_i & ~press_q;
  assign ms_cnt_d = ms_cnt_q + 1'b1;
  assign rt_cnt_d = (rt_cnt_q >= MAX_CNT) ? MAX_CNT : rt_cnt_q + 1'b1;
  assign delay_d  = MIN_DLY + CNT_W'(rand_val_i);
  assign lit_d    = lit_q + 1'b1;

  // A new run may only begin from a resting state; mid-run triggers are ignored.
  assign start_run = trig_e && (state_q == S_IDLE || state_q == S_DONE || state_q == S_JUMP);
  assign jump_now  = press_e && (state_q == S_RAMP || state_q == S_HOLD);

`ifdef F1_BEST_TIME_EN
  logic [CNT_W-1:0] best_ms_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      trig_q         <= 1'b0;
      press_q        <= 1'b0;
      ms_cnt_q       <= '0;
      rt_cnt_q       <= '0;
      delay_q        <= '0;
      lit_q          <= '0;
      ledr_q         <= '0;
      en_lfsr_q      <= 1'b1;
      lights_out_q   <= 1'b0;
      result_valid_q <= 1'b0;
      react_ms_q     <= '0;
      jump_start_q   <= 1'b0;
`ifdef F1_BEST_TIME_EN
      best_ms_q      <= MAX_CNT;
`endif
    end else begin
      trig_q         <= trigger_i;
      press_q        <= press_i;
      lights_out_q   <= 1'b0;
      result_valid_q <= 1'b0;

      if (start_run) begin
        state_q      <= S_RAMP;
        ms_cnt_q     <= '0;
        lit_q        <= '0;
        ledr_q       <= '0;
        en_lfsr_q    <= 1'b1;
        jump_start_q <= 1'b0;
      end else if (jump_now) begin
        // Early press beats any same-cycle ramp completion or hold expiry.
        state_q      <= S_JUMP;
        ms_cnt_q     <= '0;
        ledr_q       <= '1;
        en_lfsr_q    <= 1'b1;
        jump_start_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            ledr_q       <= '0;
            en_lfsr_q    <= 1'b1;
            jump_start_q <= 1'b0;
          end

          S_RAMP: begin
            if (tick_i) begin
              if (ms_cnt_q == STEP_LAST) begin
                ms_cnt_q <= '0;
                lit_q    <= lit_d;
                ledr_q   <= bar(lit_d);
                if (lit_d == LIT_FULL) begin
                  state_q   <= S_HOLD;
                  delay_q   <= delay_d;
                  en_lfsr_q <= 1'b0;
                end
              end else begin
                ms_cnt_q <= ms_cnt_d;
              end
            end
          end

          S_HOLD: begin
            if (tick_i) begin
              if (ms_cnt_d >= delay_q) begin
                state_q      <= S_TIMING;
                lights_out_q <= 1'b1;
                ledr_q       <= '0;
                rt_cnt_q     <= '0;
                ms_cnt_q     <= '0;
              end else begin
                ms_cnt_q <= ms_cnt_d;
              end
            end
          end

          S_TIMING: begin
            // A press in the same cycle as a tick freezes the count before that tick.
            if (press_e) begin
              state_q        <= S_DONE;
              react_ms_q     <= rt_cnt_q;
              result_valid_q <= 1'b1;
              en_lfsr_q      <= 1'b1;
`ifdef F1_BEST_TIME_EN
              if (rt_cnt_q < best_ms_q) begin
                best_ms_q <= rt_cnt_q;
              end
`endif
            end else if (tick_i) begin
              rt_cnt_q <= rt_cnt_d;
            end
          end

          S_DONE: begin
            ledr_q    <= '0;
            en_lfsr_q <= 1'b1;
          end

          S_JUMP: begin
            en_lfsr_q    <= 1'b1;
            jump_start_q <= 1'b1;
            if (tick_i) begin
              if (ms_cnt_q == STEP_LAST) begin
                ms_cnt_q <= '0;
                ledr_q   <= ~ledr_q;
              end else begin
                ms_cnt_q <= ms_cnt_d;
              end
            end
          end

          default: begin
            state_q      <= S_IDLE;
            ledr_q       <= '0;
            en_lfsr_q    <= 1'b1;
            jump_start_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign en_lfsr_o      = en_lfsr_q;
  assign ledr_o         = ledr_q;
  assign lights_out_o   = lights_out_q;
  assign result_valid_o = result_valid_q;
  assign react_ms_o     = react_ms_q;
  assign jump_start_o   = jump_start_q;

`ifdef F1_BEST_TIME_EN
  assign best_ms_o = best_ms_q;
`else
  assign best_ms_o = MAX_CNT;
`endif

endmodule
